vga_pixel_fetch: RTL and testbench

- Sits directly downstream of the VGA timing generator.
- Consumes its pixel coordinates, display-enable and sync outputs, and fetches 12-bit RGB from a double-buffered 320x240 framebuffer in synchronous block RAM, with 2x pixel replication to 640x480.
- Drives the VGA pins with colour and syncs re-aligned to the fetch pipeline.
- Emits a vblank pulse and performs tear-free buffer swaps at vblank.

---
 rtl/vga_pixel_fetch.sv | 132 +++++++++++++
 tb/tb_vga_pixel_fetch.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_pixel_fetch.sv
// ============================================================================
// Module   : vga_pixel_fetch
// Purpose  : Fetches 12-bit RGB from a double-buffered 320x240 framebuffer
//            with 2x replication to 640x480, realigning syncs to the pipeline.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_pixel_fetch #(
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int FB_WIDTH  = 320,
    parameter int FB_HEIGHT = 240
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  pixel_addr_x,
    input  logic [9:0]  pixel_addr_y,
    input  logic        display_in,
    input  logic        h_sync_in,
    input  logic        v_sync_in,
    input  logic        buf_sel_req,
    output logic [17:0] fb_addr,
    output logic        fb_rd_en,
    input  logic [11:0] fb_rd_data,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        h_sync_out,
    output logic        v_sync_out,
    output logic        vblank_pulse,
    output logic        buf_displayed
);

    localparam logic [9:0] c_H_ACTIVE  = H_ACTIVE[9:0];
    localparam logic [9:0] c_V_ACTIVE  = V_ACTIVE[9:0];
    localparam logic [8:0] c_FB_WIDTH  = FB_WIDTH[8:0];
    localparam logic [8:0] c_FB_HEIGHT = FB_HEIGHT[8:0];

    logic [8:0]  w_x_half;
    logic [8:0]  w_y_half;
    logic [16:0] w_y_ext;
    logic [16:0] w_offset;
    logic        w_active;
    logic        w_vblank_entry;

    logic [9:0]  r_y_prev;
    logic        r_display_d1;
    logic        r_display_d2;
    logic        r_h_sync_d1;
    logic        r_h_sync_d2;
    logic        r_v_sync_d1;
    logic        r_v_sync_d2;

    assign w_x_half = pixel_addr_x[9:1];
    assign w_y_half = pixel_addr_y[9:1];
    assign w_y_ext  = {8'd0, w_y_half};

    // y*320 as y*256 + y*64 keeps the offset out of a hard multiplier
    assign w_offset = (w_y_ext << 8) + (w_y_ext << 6) + {8'd0, w_x_half};

    assign w_active = display_in
                   && (pixel_addr_x < c_H_ACTIVE) && (pixel_addr_y < c_V_ACTIVE)
                   && (w_x_half < c_FB_WIDTH) && (w_y_half < c_FB_HEIGHT);

    assign w_vblank_entry = (pixel_addr_y == c_V_ACTIVE) && (r_y_prev != c_V_ACTIVE);

    // Stage 1: address issue; fb_addr holds while outside the active area
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fb_addr      <= 18'd0;
            fb_rd_en     <= 1'b0;
            r_display_d1 <= 1'b0;
            r_h_sync_d1  <= 1'b1;
            r_v_sync_d1  <= 1'b1;
        end else begin
            fb_rd_en     <= w_active;
            r_display_d1 <= w_active;
            r_h_sync_d1  <= h_sync_in;
            r_v_sync_d1  <= v_sync_in;
            if (w_active) begin
                fb_addr <= {buf_displayed, w_offset};
            end
        end
    end

    // Stage 2: RAM access cycle; control shifts alongside the read
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_display_d2 <= 1'b0;
            r_h_sync_d2  <= 1'b1;
            r_v_sync_d2  <= 1'b1;
        end else begin
            r_display_d2 <= r_display_d1;
            r_h_sync_d2  <= r_h_sync_d1;
            r_v_sync_d2  <= r_v_sync_d1;
        end
    end

    // Stage 3: pin registers, colour blanked whenever the pixel was inactive
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vga_r      <= 4'd0;
            vga_g      <= 4'd0;
            vga_b      <= 4'd0;
            h_sync_out <= 1'b1;
            v_sync_out <= 1'b1;
        end else begin
            {vga_r, vga_g, vga_b} <= r_display_d2 ? fb_rd_data : 12'h000;
            h_sync_out <= r_h_sync_d2;
            v_sync_out <= r_v_sync_d2;
        end
    end

    // Buffer swap only on vblank entry so a frame never mixes two buffers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_y_prev      <= 10'd0;
            vblank_pulse  <= 1'b0;
            buf_displayed <= 1'b0;
        end else begin
            r_y_prev     <= pixel_addr_y;
            vblank_pulse <= w_vblank_entry;
            if (w_vblank_entry) begin
                buf_displayed <= buf_sel_req;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_vga_pixel_fetch.sv
// ============================================================================
// Module   : tb_vga_pixel_fetch
// Purpose  : Randomized self-checking bench for vga_pixel_fetch.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_pixel_fetch;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [9:0]  pixel_addr_x = 10'd0;
    logic [9:0]  pixel_addr_y = 10'd0;
    logic        display_in = 1'b0;
    logic        h_sync_in = 1'b1;
    logic        v_sync_in = 1'b1;
    logic        buf_sel_req = 1'b0;
    logic [17:0] fb_addr;
    logic        fb_rd_en;
    logic [11:0] fb_rd_data = 12'h000;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        h_sync_out, v_sync_out, vblank_pulse, buf_displayed;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    logic [11:0] p_rgb [3];
    bit          p_hs [3];
    bit          p_vs [3];
    bit          m_buf, m_pulse, m_rden;
    logic [17:0] m_addr;
    int          m_prev_y;

    vga_pixel_fetch dut (
        .clk(clk), .reset(reset),
        .pixel_addr_x(pixel_addr_x), .pixel_addr_y(pixel_addr_y),
        .display_in(display_in), .h_sync_in(h_sync_in), .v_sync_in(v_sync_in),
        .buf_sel_req(buf_sel_req),
        .fb_addr(fb_addr), .fb_rd_en(fb_rd_en), .fb_rd_data(fb_rd_data),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .h_sync_out(h_sync_out), .v_sync_out(v_sync_out),
        .vblank_pulse(vblank_pulse), .buf_displayed(buf_displayed)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] ram_word(input logic [17:0] a);
        return a[11:0] ^ {a[17:12], a[17:12]} ^ 12'h5A3;
    endfunction

    // synchronous RAM, reads every cycle so stale nonzero data is always present
    always @(posedge clk) fb_rd_data <= ram_word(fb_addr);

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 3; i++) begin
            p_rgb[i] = 12'h000;
            p_hs[i]  = 1'b1;
            p_vs[i]  = 1'b1;
        end
        m_buf = 0; m_pulse = 0; m_rden = 0; m_addr = 18'd0; m_prev_y = 0;
    endtask

    task automatic model_edge();
        int  x, y, off;
        bit  act;
        logic [16:0] off17;
        if (!reset) begin
            model_clear();
        end else begin
            x   = int'(pixel_addr_x);
            y   = int'(pixel_addr_y);
            act = display_in && (x < 640) && (y < 480);
            off = (y / 2) * 320 + (x / 2);
            off17 = off[16:0];
            for (int i = 2; i > 0; i--) begin
                p_rgb[i] = p_rgb[i-1];
                p_hs[i]  = p_hs[i-1];
                p_vs[i]  = p_vs[i-1];
            end
            p_rgb[0] = act ? ram_word({m_buf, off17}) : 12'h000;
            p_hs[0]  = h_sync_in;
            p_vs[0]  = v_sync_in;
            m_rden   = act;
            if (act) m_addr = {m_buf, off17};
            m_pulse  = (y == 480) && (m_prev_y != 480);
            if (m_pulse) m_buf = buf_sel_req;
            m_prev_y = y;
        end
    endtask

    task automatic check_outputs();
        check_value("rgb", {20'd0, vga_r, vga_g, vga_b}, {20'd0, p_rgb[2]});
        check_value("h_sync_out", {31'd0, h_sync_out}, {31'd0, p_hs[2]});
        check_value("v_sync_out", {31'd0, v_sync_out}, {31'd0, p_vs[2]});
        check_value("fb_rd_en", {31'd0, fb_rd_en}, {31'd0, m_rden});
        check_value("vblank_pulse", {31'd0, vblank_pulse}, {31'd0, m_pulse});
        check_value("buf_displayed", {31'd0, buf_displayed}, {31'd0, m_buf});
        if (m_rden || !reset) check_value("fb_addr", {14'd0, fb_addr}, {14'd0, m_addr});
    endtask

    task automatic tick(input int x, input int y, input bit disp, input bit hs, input bit vs);
        pixel_addr_x = x[9:0];
        pixel_addr_y = y[9:0];
        display_in   = disp;
        h_sync_in    = hs;
        v_sync_in    = vs;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic rand_tick();
        int y;
        y = ($urandom_range(9) == 0) ? 480 : int'($urandom_range(524));
        tick(int'($urandom_range(799)), y, $urandom_range(3) != 0,
             $urandom_range(1) == 1, $urandom_range(1) == 1);
    endtask

    task automatic run_frame(input bit flip_at_100, input int reset_at_y, output int pulses);
        int x;
        bit vs;
        pulses = 0;
        for (int y = 0; y < 525; y++) begin
            vs = !(y == 490 || y == 491);
            if (flip_at_100 && y == 100) buf_sel_req = 1'b1;
            else if (!flip_at_100 && $urandom_range(15) == 0) buf_sel_req = ~buf_sel_req;
            if (y == reset_at_y) begin
                reset = 1'b0;
                for (int k = 0; k < 3; k++) rand_tick();
                check_value("buf_after_reset", {31'd0, buf_displayed}, 32'd0);
                reset = 1'b1;
            end
            for (int k = 0; k < 6; k++) begin
                case (k)
                    0: x = 0;
                    1: x = 5;
                    2: x = int'($urandom_range(639));
                    3: x = 639;
                    4: x = 640;
                    default: x = int'($urandom_range(799, 641));
                endcase
                tick(x, y, (x < 640) && (y < 480), 1'b1, vs);
                if (vblank_pulse) pulses++;
            end
            tick(700, y, 1'b0, 1'b0, vs);
            if (vblank_pulse) pulses++;
            tick(720, y, 1'b0, 1'b1, vs);
            if (vblank_pulse) pulses++;
        end
    endtask

    initial begin
        int pulses;
        int hs_low;
        model_clear();

        // reset held with toggling inputs
        for (int i = 0; i < 6; i++) rand_tick();
        reset = 1'b1;

        // first sample: x=5, y=7, buffer 0 -> offset 3*320+2
        tick(5, 7, 1'b1, 1'b1, 1'b1);
        check_value("addr_962", {14'd0, fb_addr}, 32'd962);
        check_value("rden_first", {31'd0, fb_rd_en}, 32'd1);
        tick(640, 7, 1'b0, 1'b1, 1'b1);
        tick(641, 7, 1'b0, 1'b1, 1'b1);
        check_value("rgb_962", {20'd0, vga_r, vga_g, vga_b}, {20'd0, ram_word(18'd962)});

        // frame with buffer request flipping mid-frame
        buf_sel_req = 1'b0;
        run_frame(1'b1, -1, pulses);
        check_value("pulses_frame1", pulses, 32'd1);
        check_value("buf_swapped", {31'd0, buf_displayed}, 32'd1);

        // last pixel of buffer 1
        tick(639, 479, 1'b1, 1'b1, 1'b1);
        check_value("addr_max", {14'd0, fb_addr}, {14'd0, 1'b1, 17'd76799});

        // 384-clk h sync pulse must come out exactly as wide
        hs_low = 0;
        for (int i = 0; i < 384; i++) begin
            tick(660, 10, 1'b0, 1'b0, 1'b1);
            if (!h_sync_out) hs_low++;
        end
        for (int i = 0; i < 6; i++) begin
            tick(i, 11, 1'b1, 1'b1, 1'b1);
            if (!h_sync_out) hs_low++;
        end
        check_value("hsync_width", hs_low, 32'd384);

        for (int i = 0; i < 1500; i++) begin
            buf_sel_req = $urandom_range(1) == 1;
            rand_tick();
        end

        // frame with a mid-frame reset
        run_frame(1'b0, 200, pulses);
        check_value("pulses_frame2", pulses, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
